// File: rtl/pulse_counter_mc.sv
// Multi-channel edge counter behind an AXI4-Lite slave: per-channel edge modes,
// free-run or gated-window counting with snapshot, and a level interrupt.
`timescale 1ns/1ps
module pulse_counter_mc #(
  parameter int NUM_CH               = 4,
  parameter int CNT_WIDTH            = 32,
  parameter int SYNC_STAGES          = 2,
  parameter int C_S00_AXI_ADDR_WIDTH = 6
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [31:0]                     s00_axi_wdata,
  input  logic [3:0]                      s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [31:0]                     s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [NUM_CH-1:0]               pulse_in,
  output logic                            irq
);

  localparam int WORD_W = C_S00_AXI_ADDR_WIDTH - 2;
  localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_EDGE   = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_WINDOW = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_IRQEN  = WORD_W'(4);

  logic                   ctrl_en, ctrl_gate;
  logic [2*NUM_CH-1:0]    edge_cfg;
  logic [31:0]            window;
  logic                   irq_en_win, win_done;
  logic [NUM_CH-1:0]      irq_en_ovf, ovf;
  logic [31:0]            win_cnt;
  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      prev_q, level, inc, ovf_set;
  logic [CNT_WIDTH-1:0]   count_q [NUM_CH];
  logic [CNT_WIDTH-1:0]   snap_q  [NUM_CH];

  function automatic logic [31:0] merge_strb(input logic [31:0] cur, input logic [31:0] val,
                                             input logic [3:0] strb);
    merge_strb = cur;
    for (int b = 0; b < 4; b++)
      if (strb[b]) merge_strb[8*b +: 8] = val[8*b +: 8];
  endfunction

  // Write side: awready/wready are one flop; the register update happens on the edge it is high.
  logic              wr_en, ctrl_wr, status_wr, snap_req, clr_req, w1c_win;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [NUM_CH-1:0] w1c_ovf;
  logic [31:0]       edge_merged, irq_merged, rd_mux;

  assign wr_en       = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign wr_word     = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign rd_word     = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
  assign ctrl_wr     = wr_en && (wr_word == W_CTRL);
  assign status_wr   = wr_en && (wr_word == W_STATUS);
  assign snap_req    = ctrl_wr & s00_axi_wstrb[0] & s00_axi_wdata[2];
  assign clr_req     = ctrl_wr & s00_axi_wstrb[0] & s00_axi_wdata[3];
  assign w1c_win     = status_wr & s00_axi_wstrb[0] & s00_axi_wdata[0];
  assign w1c_ovf     = (status_wr & s00_axi_wstrb[1]) ? s00_axi_wdata[8 +: NUM_CH] : '0;
  assign edge_merged = merge_strb(32'(edge_cfg), s00_axi_wdata, s00_axi_wstrb);
  assign irq_merged  = merge_strb((32'(irq_en_ovf) << 8) | 32'(irq_en_win), s00_axi_wdata,
                                  s00_axi_wstrb);

  assign s00_axi_wready = s00_axi_awready;
  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], edge_merged, irq_merged};

  // Window: one close per WINDOW clocks; held at WINDOW while not gating.
  logic win_active, win_close;
  assign win_active = ctrl_en & ctrl_gate & (window != 32'd0);
  assign win_close  = win_active & (win_cnt == 32'd1);

  // NOTE: always_comb assigns every output a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    inc     = '0;
    ovf_set = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      level[ch] = sync_q[ch][SYNC_STAGES-1];
      unique case (edge_cfg[2*ch +: 2])
        2'b00:   inc[ch] = ctrl_en & level[ch] & ~prev_q[ch];
        2'b01:   inc[ch] = ctrl_en & ~level[ch] & prev_q[ch];
        2'b10:   inc[ch] = ctrl_en & (level[ch] ^ prev_q[ch]);
        default: inc[ch] = 1'b0;
      endcase
      ovf_set[ch] = inc[ch] & ~clr_req & (count_q[ch] == '1);
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (rd_word)
      W_CTRL:   rd_mux = {30'd0, ctrl_gate, ctrl_en};
      W_EDGE:   rd_mux = 32'(edge_cfg);
      W_WINDOW: rd_mux = window;
      W_STATUS: rd_mux = (32'(ovf) << 8) | 32'(win_done);
      W_IRQEN:  rd_mux = (32'(irq_en_ovf) << 8) | 32'(irq_en_win);
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++)
          if (rd_word == WORD_W'(8 + ch)) rd_mux = 32'(snap_q[ch]);
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_awready <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_awready <= ~s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
      if (wr_en)               s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
      s00_axi_arready <= ~s00_axi_arready & s00_axi_arvalid & ~s00_axi_rvalid;
      if (s00_axi_arready && s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ctrl_en    <= 1'b0;
      ctrl_gate  <= 1'b0;
      edge_cfg   <= '0;
      window     <= '0;
      irq_en_win <= 1'b0;
      irq_en_ovf <= '0;
      win_done   <= 1'b0;
      ovf        <= '0;
      irq        <= 1'b0;
      win_cnt    <= '0;
    end else begin
      if (ctrl_wr && s00_axi_wstrb[0]) begin
        ctrl_en   <= s00_axi_wdata[0];
        ctrl_gate <= s00_axi_wdata[1];
      end
      if (wr_en && wr_word == W_EDGE)   edge_cfg <= edge_merged[2*NUM_CH-1:0];
      if (wr_en && wr_word == W_WINDOW) window   <= merge_strb(window, s00_axi_wdata, s00_axi_wstrb);
      if (wr_en && wr_word == W_IRQEN) begin
        irq_en_win <= irq_merged[0];
        irq_en_ovf <= irq_merged[8 +: NUM_CH];
      end
      // A set in the same cycle as its W1C wins.
      win_done <= (win_done & ~w1c_win) | win_close;
      ovf      <= (ovf & ~w1c_ovf) | ovf_set;
      irq      <= |({ovf, win_done} & {irq_en_ovf, irq_en_win});
      if (!win_active || clr_req || win_close || win_cnt == 32'd0) win_cnt <= window;
      else                                                          win_cnt <= win_cnt - 32'd1;
    end
  end

  // NOTE: the counter and snapshot arrays are reset because software expects them at 0 after reset.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      prev_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch]  <= '0;
        count_q[ch] <= '0;
        snap_q[ch]  <= '0;
      end
    end else begin
      prev_q <= level;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], pulse_in[ch]};
        if (win_close)                   snap_q[ch] <= count_q[ch] + CNT_WIDTH'(inc[ch]);
        else if (snap_req && !ctrl_gate) snap_q[ch] <= count_q[ch];
        // Clear beats a same-cycle edge; a window close restarts the count.
        if (clr_req || win_close) count_q[ch] <= '0;
        else if (inc[ch])         count_q[ch] <= count_q[ch] + CNT_WIDTH'(1);
      end
    end
  end

endmodule
